dmem_responder: RTL and testbench

// Data-memory responder serving load/store requests issued by the memory-access stage.

---
 rtl/riscv_mem_pkg.sv | 32 +++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Contents: access size encoding, responder FSM states, and an
// alignment check used when a request is accepted.
package riscv_mem_pkg;

    // Access size as carried on req_size. The encoding 2'b11 is not a member and is
    // reported as an error.
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // A halfword must sit on an even address. A word must sit on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_H:   mis = addr_lo[0];
            MEM_W:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_wdata, req_size, req_unsigned : request payload
//   resp_valid, resp_rdata, resp_err : single-cycle response, no back-pressure
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Write side: size + addr[1:0] -> lane_we[3:0], plus store data replicated
//             across the lanes so that each enabled lane sees the correct byte.
// Read side:  the raw 32-bit word is shifted down by addr[1:0] and then
//             sign- or zero-extended according to size/unsigned.
// Ports: wr_size, wr_addr_lo, wr_data -> lane_we, lane_wdata
//        rd_size, rd_addr_lo, rd_unsigned, rd_word -> rd_data
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_addr_lo,
    input  logic [31:0] wr_data,
    output logic [3:0]  lane_we,
    output logic [31:0] lane_wdata,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic        rd_unsigned,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);
    logic [31:0] rd_shift;

    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = wr_data;
        case (wr_size)
            MEM_B: begin
                lane_we    = 4'b0001 << wr_addr_lo;
                lane_wdata = {4{wr_data[7:0]}};
            end
            MEM_H: begin
                lane_we    = wr_addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wr_data[15:0]}};
            end
            MEM_W: begin
                lane_we    = 4'b1111;
                lane_wdata = wr_data;
            end
            default: begin
                lane_we    = 4'b0000;
                lane_wdata = wr_data;
            end
        endcase
    end

    always_comb begin
        rd_shift = rd_word >> {rd_addr_lo, 3'b000};
        rd_data  = 32'h0;
        case (rd_size)
            MEM_B:   rd_data = rd_unsigned ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            MEM_H:   rd_data = rd_unsigned ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            MEM_W:   rd_data = rd_word;
            default: rd_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-access stage.
// Accepts one load/store at a time, models LATENCY cycles of access time,
// commits stores through per-lane byte enables and returns a one-cycle
// response pulse with extended load data or an error flag.
// Ports: clk, rst_n (async, active low), bus (slave side of
//        dmem_responder_if), busy (high whenever the FSM is not in IDLE).
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic              we_reg, uns_reg, err_reg;
    logic [31:0]       addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        size_reg;

    logic              accept;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [1:0]        cur_size;
    logic              cur_err;
    logic              enter_resp;
    logic              wr_en, rd_en;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       rd_data;
    logic [7:0]        rbyte_reg [4];

    assign accept = (state_reg == IDLE) && bus.req_valid;

    // On the acceptance edge the latched copy is not loaded yet, so the
    // request is taken straight from the bus; afterwards from the latches.
    assign cur_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
    assign cur_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
    assign cur_size  = (state_reg == IDLE) ? bus.req_size  : size_reg;
    assign cur_err   = (cur_size == 2'b11)
                     || is_misaligned(cur_size, cur_addr[1:0])
                     || (cur_addr[31:2] >= 30'(DEPTH_WORDS));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (cur_err) begin
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_W'(LATENCY - 1);
                        state_next = (LATENCY == 1) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= bus.req_we;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                err_reg   <= cur_err;
            end
        end
    end

    // Memory is touched only on the edge that enters RESP. A reset during WAIT
    // therefore never reaches the commit.
    assign enter_resp = (state_next == RESP) && (state_reg != RESP) && rst_n;
    assign wr_en      = enter_resp && cur_we && !cur_err;
    assign rd_en      = enter_resp && !cur_we && !cur_err;
    assign idx        = cur_addr[IDX_W+1:2];

    dmem_lane_align u_align (
        .wr_size     (cur_size),
        .wr_addr_lo  (cur_addr[1:0]),
        .wr_data     (cur_wdata),
        .lane_we     (lane_we),
        .lane_wdata  (lane_wdata),
        .rd_size     (size_reg),
        .rd_addr_lo  (addr_reg[1:0]),
        .rd_unsigned (uns_reg),
        .rd_word     (rd_word),
        .rd_data     (rd_data)
    );

    // One byte-wide bank per lane with a registered read port. The banks have
    // no reset, so memory contents survive rst_n.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] mem_bank [DEPTH_WORDS];
            always_ff @(posedge clk) begin
                if (wr_en && lane_we[gi]) mem_bank[idx] <= lane_wdata[8*gi +: 8];
                if (rd_en) rbyte_reg[gi] <= mem_bank[idx];
            end
            assign rd_word[8*gi +: 8] = rbyte_reg[gi];
        end
    endgenerate

    assign bus.req_ready  = (state_reg == IDLE);
    assign busy           = (state_reg != IDLE);
    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_err   = (state_reg == RESP) && err_reg;
    assign bus.resp_rdata = ((state_reg == RESP) && !err_reg && !we_reg) ? rd_data : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy3;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus3 ();

    dmem_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy)
    );
    dmem_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One transaction on the LATENCY=2 DUT; returns response data, error flag and
    // the number of negedges from acceptance to resp_valid.
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rd, output logic err, output int n);
        logic got;
        @(negedge clk);
        bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_size = size; bus.req_unsigned = uns; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) got = 1'b1;
        end
        rd = bus.resp_rdata; err = bus.resp_err;
        if (!got) begin
            total++;
            $display("FAIL timeout: no resp_valid for addr %h within 20 cycles", addr);
        end
        $display("txn we=%0b addr=%h wdata=%h size=%0d uns=%0b -> rdata=%h err=%0b lat=%0d",
                 we, addr, wdata, size, uns, rd, err, n);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n;
        int          seen;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.req_size = 0; bus.req_unsigned = 0;
        bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = 0; bus3.req_wdata = 0;
        bus3.req_size = 0; bus3.req_unsigned = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err",   {31'h0, bus.resp_err}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        rst_n = 1'b1;

        // Word store/load and latency
        req(1'b1, 32'h0, 32'hF000_0000, 2'b10, 1'b0, rd, err, n);
        check("sw0_err", {31'h0, err}, 32'h0);
        check("sw0_lat", n, 32'd2);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("lw0_data", rd, 32'hF000_0000);
        check("lw0_err", {31'h0, err}, 32'h0);
        check("lw0_lat", n, 32'd2);

        // Byte store, signed/unsigned byte loads, word view
        req(1'b1, 32'h4, 32'h0, 2'b10, 1'b0, rd, err, n);
        req(1'b1, 32'h5, 32'h80, 2'b00, 1'b0, rd, err, n);
        req(1'b0, 32'h5, 32'h0, 2'b00, 1'b0, rd, err, n);
        check("lb5", rd, 32'hFFFF_FF80);
        req(1'b0, 32'h5, 32'h0, 2'b00, 1'b1, rd, err, n);
        check("lbu5", rd, 32'h0000_0080);
        req(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("lw4", rd, 32'h0000_8000);

        // Half store, signed/unsigned half loads
        req(1'b1, 32'h2, 32'hBEEF, 2'b01, 1'b0, rd, err, n);
        req(1'b0, 32'h2, 32'h0, 2'b01, 1'b0, rd, err, n);
        check("lh2", rd, 32'hFFFF_BEEF);
        req(1'b0, 32'h2, 32'h0, 2'b01, 1'b1, rd, err, n);
        check("lhu2", rd, 32'h0000_BEEF);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("lw0_half", rd, 32'hBEEF_0000);

        // Error cases
        req(1'b0, 32'h6, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("lw6_err", {31'h0, err}, 32'h1);
        check("lw6_rdata", rd, 32'h0);
        req(1'b1, 32'h1, 32'h1234, 2'b01, 1'b0, rd, err, n);
        check("sh1_err", {31'h0, err}, 32'h1);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("lw0_nochg", rd, 32'hBEEF_0000);
        req(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("oor_ld_err", {31'h0, err}, 32'h1);
        req(1'b1, 32'h0000_1FFC, 32'h5555_5555, 2'b10, 1'b0, rd, err, n);
        check("oor_st_err", {31'h0, err}, 32'h1);
        req(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, rd, err, n);
        check("size11_err", {31'h0, err}, 32'h1);
        req(1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("last_idx_ok", {31'h0, err}, 32'h0);

        // Handshake on the LATENCY=3 instance with req_valid held high
        @(negedge clk);
        bus3.req_we = 1'b1; bus3.req_addr = 32'h0; bus3.req_wdata = 32'h1;
        bus3.req_size = 2'b10; bus3.req_unsigned = 1'b0; bus3.req_valid = 1'b1;
        check("hs_ready0", {31'h0, bus3.req_ready}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("hs_ready_c%0d", i), {31'h0, bus3.req_ready}, 32'h0);
            check($sformatf("hs_busy_c%0d", i), {31'h0, busy3}, 32'h1);
            check($sformatf("hs_rvalid_c%0d", i), {31'h0, bus3.resp_valid}, (i == 3) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        check("hs_idle_ready", {31'h0, bus3.req_ready}, 32'h1);
        check("hs_idle_busy", {31'h0, busy3}, 32'h0);
        @(negedge clk);
        check("hs_second_acc", {31'h0, busy3}, 32'h1);
        bus3.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (bus3.resp_valid) seen = i + 2;
        end
        check("hs_second_lat", seen, 32'd3);
        $display("txn handshake LATENCY=3 second response at cycle %0d", seen);

        // Reset during WAIT aborts the store
        req(1'b1, 32'h8, 32'h1122_3344, 2'b10, 1'b0, rd, err, n);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 32'h8; bus.req_wdata = 32'hDEAD_BEEF;
        bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("abort_no_resp", seen, 32'd0);
        $display("txn reset during WAIT, resp pulses seen=%0d", seen);
        req(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd, err, n);
        check("abort_lw8", rd, 32'h1122_3344);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
